weight_dma_loader: RTL and testbench

WEIGHT_DMA_LOADER -- requirements
Module: weight_dma_loader

---
 rtl/weight_dma_loader.sv | 151 +++++++++++++++
 tb/tb_weight_dma_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_dma_loader.sv
// Weight DMA loader: packs half-width stream beats into full SRAM words for the
// inactive bank, then issues a bank swap once compute has released the active bank.
module weight_dma_loader #(
    parameter int SRAM_ADDR_W = 10,
    parameter int SRAM_WIDTH  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [SRAM_ADDR_W:0]    tile_words_i,
    input  logic                    s_tvalid_i,
    output logic                    s_tready_o,
    input  logic [SRAM_WIDTH/2-1:0] s_tdata_i,
    input  logic                    s_tlast_i,
    input  logic                    compute_done_i,
    output logic                    wr_en_o,
    output logic [SRAM_ADDR_W-1:0]  wr_addr_o,
    output logic [SRAM_WIDTH-1:0]   wr_data_o,
    output logic                    bank_swap_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    len_err_o
);
    localparam int HALF_W = SRAM_WIDTH / 2;
    localparam logic [SRAM_ADDR_W:0] SRAM_DEPTH = {1'b1, {SRAM_ADDR_W{1'b0}}};
    localparam logic [SRAM_ADDR_W:0] WORD_ONE   = {{SRAM_ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP, SWAP} state_e;

    state_e                state_q, state_d;
    logic [SRAM_ADDR_W:0]  len_q, len_d;
    logic [SRAM_ADDR_W:0]  word_q, word_d;
    logic                  odd_q, odd_d;
    logic                  swap_ok_q, swap_ok_d;
    logic                  wr_en_q, wr_en_d;
    logic                  len_err_q, len_err_d;
    logic [HALF_W-1:0]     lo_q;
    logic [SRAM_ADDR_W-1:0] wr_addr_q;
    logic [SRAM_WIDTH-1:0] wr_data_q;
    logic                  lo_load;
    logic                  wr_load;
    logic                  final_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            word_q    <= '0;
            odd_q     <= 1'b0;
            swap_ok_q <= 1'b1;
            wr_en_q   <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            word_q    <= word_d;
            odd_q     <= odd_d;
            swap_ok_q <= swap_ok_d;
            wr_en_q   <= wr_en_d;
            len_err_q <= len_err_d;
        end
    end

    // Datapath registers are only meaningful while wr_en is high, so they carry no reset.
    always_ff @(posedge clk) begin
        if (lo_load) begin
            lo_q <= s_tdata_i;
        end
        if (wr_load) begin
            wr_addr_q <= word_q[SRAM_ADDR_W-1:0];
            wr_data_q <= {s_tdata_i, lo_q};
        end
    end

    assign final_beat = odd_q && (word_q == len_q - WORD_ONE);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_d      = word_q;
        odd_d       = odd_q;
        swap_ok_d   = swap_ok_q;
        wr_en_d     = 1'b0;
        len_err_d   = 1'b0;
        lo_load     = 1'b0;
        wr_load     = 1'b0;
        s_tready_o  = (state_q == LOAD);
        busy_o      = (state_q != IDLE);
        bank_swap_o = (state_q == SWAP);
        done_o      = (state_q == SWAP);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (tile_words_i != '0 && tile_words_i <= SRAM_DEPTH) begin
                        len_d   = tile_words_i;
                        word_d  = '0;
                        odd_d   = 1'b0;
                        state_d = LOAD;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (s_tvalid_i) begin
                    // An early tlast aborts the tile without writing the beat it arrived on.
                    if (s_tlast_i && !final_beat) begin
                        len_err_d = 1'b1;
                        state_d   = IDLE;
                    end else if (!odd_q) begin
                        lo_load = 1'b1;
                        odd_d   = 1'b1;
                    end else begin
                        wr_en_d = 1'b1;
                        wr_load = 1'b1;
                        word_d  = word_q + WORD_ONE;
                        odd_d   = 1'b0;
                        if (final_beat) begin
                            state_d   = WAIT_SWAP;
                            len_err_d = !s_tlast_i;
                        end
                    end
                end
            end
            WAIT_SWAP: begin
                if (swap_ok_q || compute_done_i) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (compute_done_i) begin
            swap_ok_d = 1'b1;
        end else if (state_q == SWAP) begin
            swap_ok_d = 1'b0;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign len_err_o = len_err_q;

endmodule

// File: tb/tb_weight_dma_loader.sv
// Directed bench for weight_dma_loader: a beat-level reference model checked every
// cycle, plus literal expectations on the logged writes, swaps and errors.
module tb_weight_dma_loader;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [10:0] tileWords;
    logic        sTvalid;
    logic        sTready;
    logic [31:0] sTdata;
    logic        sTlast;
    logic        computeDone;
    logic        wrEn;
    logic [9:0]  wrAddr;
    logic [63:0] wrData;
    logic        bankSwap;
    logic        busy;
    logic        done;
    logic        lenErr;

    int assertCount = 0;
    int failCount   = 0;
    int cycle       = 0;
    int lenErrCount = 0;
    int cdCycle     = 0;

    logic [63:0] wrLogData[$];
    int          wrLogAddr[$];
    int          wrLogCycle[$];
    int          swapLog[$];

    int          mPhase;
    int          mLen;
    logic [31:0] mBeats[$];
    logic        mCredit;
    logic        expWrEn;
    int          expWrAddr;
    logic [63:0] expWrData;
    logic        expLenErr;

    weight_dma_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .tile_words_i   (tileWords),
        .s_tvalid_i     (sTvalid),
        .s_tready_o     (sTready),
        .s_tdata_i      (sTdata),
        .s_tlast_i      (sTlast),
        .compute_done_i (computeDone),
        .wr_en_o        (wrEn),
        .wr_addr_o      (wrAddr),
        .wr_data_o      (wrData),
        .bank_swap_o    (bankSwap),
        .busy_o         (busy),
        .done_o         (done),
        .len_err_o      (lenErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic void modelReset();
        mPhase    = 0;
        mLen      = 0;
        mBeats.delete();
        mCredit   = 1'b1;
        expWrEn   = 1'b0;
        expWrAddr = 0;
        expWrData = '0;
        expLenErr = 1'b0;
    endfunction

    // Phases: 0 idle, 1 collecting beats, 2 waiting for swap permission, 3 swapping.
    function automatic void modelStep();
        int   oldPhase;
        int   idx;
        logic isFinal;
        oldPhase  = mPhase;
        expWrEn   = 1'b0;
        expLenErr = 1'b0;
        case (oldPhase)
            0: if (start) begin
                if (tileWords == 11'd0 || tileWords > 11'd1024) begin
                    expLenErr = 1'b1;
                end else begin
                    mPhase = 1;
                    mLen   = int'(tileWords);
                    mBeats.delete();
                end
            end
            1: if (sTvalid) begin
                idx     = mBeats.size();
                isFinal = (idx == 2 * mLen - 1);
                if (sTlast && !isFinal) begin
                    expLenErr = 1'b1;
                    mPhase    = 0;
                end else begin
                    mBeats.push_back(sTdata);
                    if (idx % 2 == 1) begin
                        expWrEn   = 1'b1;
                        expWrAddr = idx / 2;
                        expWrData = {sTdata, mBeats[idx-1]};
                    end
                    if (isFinal) begin
                        mPhase    = 2;
                        expLenErr = !sTlast;
                    end
                end
            end
            2: if (mCredit || computeDone) mPhase = 3;
            3: mPhase = 0;
            default: mPhase = 0;
        endcase
        if (computeDone) mCredit = 1'b1;
        else if (oldPhase == 3) mCredit = 1'b0;
    endfunction

    // Compare the DUT against the model mid-cycle, log DUT events, then advance the model.
    always @(negedge clk) begin
        if (!rst_n) modelReset();
        checkOutput("s_tready",  64'(sTready),  64'(mPhase == 1));
        checkOutput("busy",      64'(busy),     64'(mPhase != 0));
        checkOutput("bank_swap", 64'(bankSwap), 64'(mPhase == 3));
        checkOutput("done",      64'(done),     64'(mPhase == 3));
        checkOutput("wr_en",     64'(wrEn),     64'(expWrEn));
        checkOutput("len_err",   64'(lenErr),   64'(expLenErr));
        if (expWrEn) begin
            checkOutput("wr_addr", 64'(wrAddr), 64'(expWrAddr));
            checkOutput("wr_data", wrData, expWrData);
        end
        if (wrEn) begin
            wrLogData.push_back(wrData);
            wrLogAddr.push_back(int'(wrAddr));
            wrLogCycle.push_back(cycle);
        end
        if (bankSwap) swapLog.push_back(cycle);
        if (lenErr) lenErrCount <= lenErrCount + 1;
        if (rst_n) modelStep();
    end

    task automatic applyStimulus(input logic st, input logic [10:0] tw, input logic v,
                                 input logic [31:0] d, input logic l, input logic cd);
        start       = st;
        tileWords   = tw;
        sTvalid     = v;
        sTdata      = d;
        sTlast      = l;
        computeDone = cd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 11'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic startTile(input logic [10:0] tw);
        applyStimulus(1'b1, tw, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        applyStimulus(1'b0, 11'd0, 1'b1, d, l, 1'b0);
    endtask

    task automatic pulseComputeDone();
        cdCycle = cycle;
        applyStimulus(1'b0, 11'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic clearLogs();
        wrLogData.delete();
        wrLogAddr.delete();
        wrLogCycle.delete();
        swapLog.delete();
        lenErrCount = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; tileWords = '0; sTvalid = 1'b0; sTdata = '0; sTlast = 1'b0; computeDone = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_wr_en", 64'(wrEn), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Two-word tile without stalls; the swap follows the final write by one cycle.
        clearLogs();
        startTile(11'd2);
        beat(32'hA0A0_0001, 1'b0);
        beat(32'hB0B0_0002, 1'b0);
        beat(32'hC0C0_0003, 1'b0);
        beat(32'hD0D0_0004, 1'b1);
        idle(4);
        checkOutput("t1_write_count", 64'(wrLogData.size()), 64'd2);
        checkOutput("t1_addr0", 64'(wrLogAddr[0]), 64'd0);
        checkOutput("t1_data0", wrLogData[0], 64'hB0B0_0002_A0A0_0001);
        checkOutput("t1_addr1", 64'(wrLogAddr[1]), 64'd1);
        checkOutput("t1_data1", wrLogData[1], 64'hD0D0_0004_C0C0_0003);
        checkOutput("t1_swap_count", 64'(swapLog.size()), 64'd1);
        checkOutput("t1_swap_after_write", 64'(swapLog[0]), 64'(wrLogCycle[1] + 1));

        // One-word tile with valid toggling, including stray valids after the final beat.
        pulseComputeDone();
        clearLogs();
        startTile(11'd1);
        beat(32'h1234_5678, 1'b0);
        idle(1);
        beat(32'h9ABC_DEF0, 1'b1);
        idle(1);
        beat(32'hEEEE_EEEE, 1'b0);
        idle(1);
        beat(32'hFFFF_FFFF, 1'b0);
        idle(2);
        checkOutput("t2_write_count", 64'(wrLogData.size()), 64'd1);
        checkOutput("t2_data0", wrLogData[0], 64'h9ABC_DEF0_1234_5678);
        checkOutput("t2_swap_count", 64'(swapLog.size()), 64'd1);

        // Back-to-back tiles: the second must wait in WAIT_SWAP for compute_done.
        pulseComputeDone();
        clearLogs();
        startTile(11'd1);
        beat(32'h0000_0011, 1'b0);
        beat(32'h0000_0022, 1'b1);
        idle(1);
        startTile(11'd1);
        startTile(11'd1);
        beat(32'h0000_0033, 1'b0);
        beat(32'h0000_0044, 1'b1);
        startTile(11'd3);
        idle(4);
        checkOutput("t3_swaps_before_release", 64'(swapLog.size()), 64'd1);
        checkOutput("t3_busy_holding", 64'(busy), 64'd1);
        pulseComputeDone();
        idle(3);
        checkOutput("t3_swaps_after_release", 64'(swapLog.size()), 64'd2);
        checkOutput("t3_swap_follows_cd", 64'(swapLog[1]), 64'(cdCycle + 1));
        checkOutput("t3_second_data", wrLogData[1], 64'h0000_0044_0000_0033);

        // Early tlast on beat 3 of a four-word tile aborts without a swap.
        pulseComputeDone();
        clearLogs();
        startTile(11'd4);
        beat(32'h0B00_0000, 1'b0);
        beat(32'h0B00_0001, 1'b0);
        beat(32'h0B00_0002, 1'b0);
        beat(32'h0B00_0003, 1'b1);
        idle(3);
        checkOutput("t4_write_count", 64'(wrLogData.size()), 64'd1);
        checkOutput("t4_addr0", 64'(wrLogAddr[0]), 64'd0);
        checkOutput("t4_len_err_count", 64'(lenErrCount), 64'd1);
        checkOutput("t4_swap_count", 64'(swapLog.size()), 64'd0);

        // Missing tlast on the final beat flags an error but still completes.
        clearLogs();
        startTile(11'd1);
        beat(32'h0C00_0000, 1'b0);
        beat(32'h0C00_0001, 1'b0);
        idle(3);
        checkOutput("t5_len_err_count", 64'(lenErrCount), 64'd1);
        checkOutput("t5_swap_count", 64'(swapLog.size()), 64'd1);

        // Length bounds: 0 and 1025 are rejected, 1024 is accepted.
        clearLogs();
        startTile(11'd0);
        idle(1);
        startTile(11'd1025);
        idle(2);
        checkOutput("t6_len_err_count", 64'(lenErrCount), 64'd2);
        checkOutput("t6_busy", 64'(busy), 64'd0);
        startTile(11'd1024);
        beat(32'h0D00_0000, 1'b0);
        checkOutput("t6_busy_max_len", 64'(busy), 64'd1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);

        // Reset after three beats of a two-word tile, then a fresh tile from address 0.
        startTile(11'd2);
        beat(32'h0E00_0000, 1'b0);
        beat(32'h0E00_0001, 1'b0);
        beat(32'h0E00_0002, 1'b0);
        clearLogs();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        checkOutput("t7_no_write_after_reset", 64'(wrLogData.size()), 64'd0);
        checkOutput("t7_no_swap_after_reset", 64'(swapLog.size()), 64'd0);
        startTile(11'd2);
        beat(32'h0F00_0000, 1'b0);
        beat(32'h0F00_0001, 1'b0);
        beat(32'h0F00_0002, 1'b0);
        beat(32'h0F00_0003, 1'b1);
        idle(4);
        checkOutput("t7_write_count", 64'(wrLogData.size()), 64'd2);
        checkOutput("t7_addr0", 64'(wrLogAddr[0]), 64'd0);
        checkOutput("t7_data0", wrLogData[0], 64'h0F00_0001_0F00_0000);
        checkOutput("t7_swap_count", 64'(swapLog.size()), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
